rd_phase_cal: RTL and testbench
===============================

Name: rd_phase_cal

Overview:
- Read-capture phase calibration controller for the memory PHY.
- Drives the 4-bit PLL dynamic delay that sets the phase of `clk_rd`.
- Sweeps all 16 delay taps, asks the memory tester for a pass/fail readback at each tap, builds a pass map, then applies the tap at the centre of the longest passing window.
- Sits directly upstream of the clock/reset manager's `delay` input and runs in the `clk_1x` domain.

Parameters:
- SETTLE_CYCLES, 64: clk cycles waited after each delay change before testing (PLL phase settle); must be >= 1.
- TIMEOUT_CYCLES, 1024: max clk cycles waited for `test_ack`; on expiry the tap is recorded as fail.
- DEFAULT_DELAY, 8: delay tap applied at reset and when no tap passes.

Ports:
- clk  in  1  `clk_1x` domain clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a calibration sweep
- delay  out  4  tap value to the PLL dynamic delay input
- test_req  out  1  request one read-back test at the current tap
- test_ack  in  1  single-cycle pulse; test complete
- test_ok  in  1  test result; sampled only when `test_ack`=1
- busy  out  1  sweep or scan in progress
- done  out  1  calibration finished; sticky until next start
- error  out  1  no passing tap found; valid when `done`=1
- pass_map  out  16  bit n = 1 if tap n passed
- win_start  out  4  first tap of the selected window
- win_len  out  5  length of the selected window, 0..16

Behaviour:
- Reset values (asynchronous):
  - `delay`=DEFAULT_DELAY.
  - `test_req`, `busy`, `done`, `error` = 0.
  - `pass_map`=0, `win_start`=0, `win_len`=0.
  - FSM enters IDLE; reset mid-sweep aborts immediately with these values.
- FSM states: IDLE, SET, SETTLE, REQ, SCAN, APPLY.
- IDLE:
  - `start`=1 → SET, with tap counter=0, `busy`=1, `done`=0, `error`=0, `pass_map`=0.
  - `start` while `busy`=1 is ignored.
  - `start` while `done`=1 clears `done` and restarts the sweep.
- SET: `delay`<=tap counter (registered, 1 cycle); load settle counter; → SETTLE.
- SETTLE: counts SETTLE_CYCLES clk cycles, then → REQ with `test_req`=1 and the timeout counter cleared.
- REQ:
  - `test_req` is held high.
  - On `test_ack`: `pass_map[tap]`<=`test_ok`, `test_req`<=0.
  - On a timeout counter reaching TIMEOUT_CYCLES-1 without ack: `pass_map[tap]`<=0, `test_req`<=0.
  - Then if tap==15 → SCAN, else tap+1 → SET.
  - `test_ack` arriving in any state other than REQ is ignored.
- SCAN:
  - Walks bits 0..15 one per cycle (16 cycles), tracking the current run start/length and the best run start/length.
  - A run replaces the best only if strictly longer, so on a tie the earliest run wins.
  - No wrap-around: taps 15 and 0 are not adjacent.
  - Result goes to `win_start`/`win_len`; → APPLY.
- APPLY:
  - If `win_len`==0: `delay`<=DEFAULT_DELAY, `error`<=1.
  - Else: `delay`<=`win_start` + ((`win_len`-1)>>1), floor centre, 4-bit result, cannot overflow.
  - In both cases `busy`<=0, `done`<=1 → IDLE.
- Output stability:
  - `delay` changes only in SET or APPLY.
  - `pass_map`, `win_start`, `win_len` hold until the next `start`.
- Sweep latency: 16 × (1 + SETTLE_CYCLES + ack latency + 1) + 16 + 1 clk cycles.

Test Plan:
- All taps pass (ack after 3 cycles, `test_ok`=1) → `pass_map`=16'hFFFF, `win_start`=0, `win_len`=16, `delay`=7, `done`=1, `error`=0.
- Taps 5..9 pass → `pass_map`=16'h03E0, `win_start`=5, `win_len`=5, `delay`=7.
- Taps 1..3 and 10..14 pass → `win_start`=10, `win_len`=5, `delay`=12; tie case with taps 2..4 and 9..11 → `win_start`=2, `win_len`=3, `delay`=3.
- No tap passes → `pass_map`=0, `win_len`=0, `error`=1, `delay`=8, `done`=1.
- Tester never acks at tap 6 (TIMEOUT_CYCLES=32), others pass → `pass_map`=16'hFFBF, `win_start`=7, `win_len`=9, `delay`=11; `test_req` drops exactly 32 cycles after rising at tap 6.
- Assert `rst` during SETTLE at tap 4 → `delay`=8, `busy`=0, `test_req`=0 immediately; a spurious `test_ack` in IDLE leaves `pass_map` unchanged; a new `start` runs a full sweep correctly.

Source files
------------

// File: rtl/rd_phase_cal.sv
// rd_phase_cal -- read-capture phase calibration controller (clk_1x domain)
//
// Sweeps the 4-bit PLL dynamic delay over all 16 taps. At each tap it waits
// for the PLL phase to settle, then asks the memory tester for one read-back
// test. The results form a pass map. The controller then scans the map for
// the longest run of passing taps and applies the tap at the centre of that
// run.
//
// Ports:
//   clk        clk_1x domain clock
//   rst        asynchronous active-high reset
//   start      single-cycle pulse, begins a sweep (ignored while busy)
//   delay      tap value to the PLL dynamic delay input
//   test_req   request one read-back test at the current tap
//   test_ack   single-cycle pulse, test complete
//   test_ok    test result, sampled only with test_ack
//   busy       sweep or scan in progress
//   done       calibration finished, sticky until the next start
//   error      no passing tap found, valid with done
//   pass_map   bit n set if tap n passed
//   win_start  first tap of the selected window
//   win_len    length of the selected window, 0..16
module rd_phase_cal #(
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [3:0]  DEFAULT_DELAY  = 4'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  delay,
    output logic        test_req,
    input  logic        test_ack,
    input  logic        test_ok,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] pass_map,
    output logic [3:0]  win_start,
    output logic [4:0]  win_len
);

    localparam int unsigned SW = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SET, S_SETTLE, S_REQ, S_SCAN, S_APPLY
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    tap;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    scan_idx;
    logic [3:0]    run_start;
    logic [4:0]    run_len;

    logic          settle_last;
    logic          tmo_last;
    logic          scan_bit;
    logic [4:0]    scan_len;
    logic [3:0]    scan_start;

    // Settle counter counts down from SETTLE_CYCLES-1, so SETTLE lasts
    // exactly SETTLE_CYCLES cycles; REQ lasts at most TIMEOUT_CYCLES cycles.
    assign settle_last = (settle_cnt == '0);
    assign tmo_last    = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Run tracking for the current scan bit: a run extends on a pass and
    // restarts (length 0) on a fail; its start is latched on the first pass.
    assign scan_bit   = pass_map[scan_idx];
    assign scan_len   = scan_bit ? run_len + 5'd1 : '0;
    assign scan_start = (run_len == '0) ? scan_idx : run_start;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SET;
            S_SET:    state_nxt = S_SETTLE;
            S_SETTLE: if (settle_last) state_nxt = S_REQ;
            S_REQ:    if (test_ack || tmo_last)
                          state_nxt = (tap == 4'd15) ? S_SCAN : S_SET;
            S_SCAN:   if (scan_idx == 4'd15) state_nxt = S_APPLY;
            S_APPLY:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        test_req = (state == S_REQ);
        busy     = (state != S_IDLE);
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay      <= DEFAULT_DELAY;
            done       <= 1'b0;
            error      <= 1'b0;
            pass_map   <= '0;
            win_start  <= '0;
            win_len    <= '0;
            tap        <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            scan_idx   <= '0;
            run_start  <= '0;
            run_len    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tap       <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        pass_map  <= '0;
                        win_start <= '0;
                        win_len   <= '0;
                        scan_idx  <= '0;
                        run_start <= '0;
                        run_len   <= '0;
                    end
                end
                S_SET: begin
                    delay      <= tap;
                    settle_cnt <= SW'(SETTLE_CYCLES - 1);
                end
                S_SETTLE: begin
                    if (settle_last) tmo_cnt    <= '0;
                    else             settle_cnt <= settle_cnt - 1'b1;
                end
                S_REQ: begin
                    if (test_ack) begin
                        pass_map[tap] <= test_ok;
                        tap           <= tap + 4'd1;
                    end else if (tmo_last) begin
                        pass_map[tap] <= 1'b0;
                        tap           <= tap + 4'd1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_SCAN: begin
                    run_len   <= scan_len;
                    run_start <= scan_start;
                    // Strictly longer only: on a tie the earliest run stays.
                    if (scan_len > win_len) begin
                        win_start <= scan_start;
                        win_len   <= scan_len;
                    end
                    scan_idx <= scan_idx + 4'd1;
                end
                S_APPLY: begin
                    if (win_len == '0) begin
                        delay <= DEFAULT_DELAY;
                        error <= 1'b1;
                    end else begin
                        // Floor centre; start + (len-1)/2 never exceeds 15.
                        delay <= 4'(5'(win_start) + ((win_len - 5'd1) >> 1));
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rd_phase_cal.sv
// tb_rd_phase_cal -- self-checking bench for rd_phase_cal.
// A tester model answers each test_req; expected sweep results are queued
// when a sweep is started and popped when done rises.
module tb_rd_phase_cal;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  delay;
    logic        test_req;
    logic        test_ack;
    logic        test_ok;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] pass_map;
    logic [3:0]  win_start;
    logic [4:0]  win_len;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int TMO = 32;

    rd_phase_cal #(
        .SETTLE_CYCLES (4),
        .TIMEOUT_CYCLES(TMO),
        .DEFAULT_DELAY (4'd8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .delay    (delay),
        .test_req (test_req),
        .test_ack (test_ack),
        .test_ok  (test_ok),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .pass_map (pass_map),
        .win_start(win_start),
        .win_len  (win_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pm;
        logic [3:0]  ws;
        logic [4:0]  wl;
        logic [3:0]  dly;
        logic        err;
    } exp_t;

    typedef struct {
        logic [15:0] mask;   // test_ok returned at each tap
        int          noack;  // tap that never gets an ack, -1 for none
        exp_t        e;
    } vec_t;

    exp_t exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (test_req !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        ok = (n < 200);
        if (!ok) check("test_req_wait_timeout", 32'd0, 32'd1);
    endtask

    // Independent reference: longest run from each start tap, first wins ties.
    function automatic exp_t model(input logic [15:0] mask);
        exp_t r;
        int bs = 0, bl = 0;
        for (int s = 0; s < 16; s++) begin
            int l = 0;
            while (s + l < 16 && mask[s + l]) l++;
            if (l > bl) begin bs = s; bl = l; end
        end
        r.pm  = mask;
        r.ws  = 4'(bs);
        r.wl  = 5'(bl);
        r.err = (bl == 0);
        r.dly = (bl == 0) ? 4'd8 : 4'(bs + (bl - 1) / 2);
        return r;
    endfunction

    task automatic run_sweep(input logic [15:0] mask, input int noack,
                             input exp_t e, input bit poke_start);
        bit ok;
        exp_t x;
        int n;
        exp_q.push_back(e);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 16; t++) begin
            wait_req(ok);
            if (!ok) break;
            check($sformatf("tap%0d_delay", t), 32'(delay), 32'(t));
            if (t == 0) check("done_cleared", 32'(done), 32'd0);
            if (t == noack) begin
                n = 0;
                while (test_req === 1'b1 && n < TMO + 10) begin
                    step();
                    n++;
                end
                check("timeout_req_len", 32'(n), 32'(TMO));
            end else begin
                for (int c = 0; c < 3; c++) begin
                    start = (poke_start && t == 8 && c == 0);
                    step();
                end
                start    = 1'b0;
                test_ack = 1'b1;
                test_ok  = mask[t];
                step();
                test_ack = 1'b0;
                test_ok  = 1'b0;
            end
        end
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        x = exp_q.pop_front();
        check("pass_map",  32'(pass_map),  32'(x.pm));
        check("win_start", 32'(win_start), 32'(x.ws));
        check("win_len",   32'(win_len),   32'(x.wl));
        check("delay",     32'(delay),     32'(x.dly));
        check("error",     32'(error),     32'(x.err));
        check("busy_end",  32'(busy),      32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        bit ok;
        int n;
        logic [15:0] m;

        vecs[0] = '{16'hFFFF, -1, '{16'hFFFF, 4'd0,  5'd16, 4'd7,  1'b0}};
        vecs[1] = '{16'h03E0, -1, '{16'h03E0, 4'd5,  5'd5,  4'd7,  1'b0}};
        vecs[2] = '{16'h7C0E, -1, '{16'h7C0E, 4'd10, 5'd5,  4'd12, 1'b0}};
        vecs[3] = '{16'h0E1C, -1, '{16'h0E1C, 4'd2,  5'd3,  4'd3,  1'b0}};
        vecs[4] = '{16'h0000, -1, '{16'h0000, 4'd0,  5'd0,  4'd8,  1'b1}};
        vecs[5] = '{16'hFFFF,  6, '{16'hFFBF, 4'd7,  5'd9,  4'd11, 1'b0}};

        rst = 1'b1; start = 1'b0; test_ack = 1'b0; test_ok = 1'b0;
        step(); step();
        check("rst_delay",    32'(delay),    32'd8);
        check("rst_test_req", 32'(test_req), 32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_error",    32'(error),    32'd0);
        check("rst_pass_map", 32'(pass_map), 32'd0);
        check("rst_win",      32'({win_start, win_len}), 32'd0);
        rst = 1'b0;
        step();

        foreach (vecs[i])
            run_sweep(vecs[i].mask, vecs[i].noack, vecs[i].e, (i == 2));

        // done stays set while idle
        repeat (5) step();
        check("done_sticky", 32'(done), 32'd1);

        for (int r = 0; r < 3; r++) begin
            m = 16'($urandom);
            run_sweep(m, -1, model(m), 1'b0);
        end

        // Reset during SETTLE at tap 4
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 4; t++) begin
            wait_req(ok);
            if (!ok) break;
            test_ack = 1'b1;
            test_ok  = 1'b1;
            step();
            test_ack = 1'b0;
            test_ok  = 1'b0;
        end
        n = 0;
        while (delay !== 4'd4 && n < 50) begin
            step();
            n++;
        end
        check("reached_tap4", 32'(delay), 32'd4);
        step();
        #2 rst = 1'b1;
        #1;
        check("midrst_delay",    32'(delay),    32'd8);
        check("midrst_busy",     32'(busy),     32'd0);
        check("midrst_test_req", 32'(test_req), 32'd0);
        check("midrst_pass_map", 32'(pass_map), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Spurious ack in IDLE is ignored
        test_ack = 1'b1;
        test_ok  = 1'b1;
        step();
        test_ack = 1'b0;
        test_ok  = 1'b0;
        step();
        check("idle_ack_pass_map", 32'(pass_map), 32'd0);
        check("idle_ack_busy",     32'(busy),     32'd0);

        run_sweep(vecs[1].mask, vecs[1].noack, vecs[1].e, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
